traffic_controller_n: RTL and testbench
=======================================

# traffic_controller_n

Parametrised N-lane traffic controller, successor to the fixed four-lane `traffic_system_top`. It sequences each lane through green, yellow and all-red clearance phases with programmable durations. When choosing the next lane, it gives priority to lanes whose jam sensors are active. It sits at the top of the traffic system and drives one `allow`/`caution` pair per lane.

## Interface
- `NUM_LANES`, 4: number of lanes; must be ≥2.
- `CNT_W`, 8: phase counter width; must hold max(duration) - 1.
- `GREEN_CYCLES`, 10: base green duration in clocks; must be ≥1.
- `YELLOW_CYCLES`, 3: yellow duration in clocks; must be ≥1.
- `ALL_RED_CYCLES`, 2: all-red clearance duration in clocks; must be ≥1.
- `MAX_EXTEND_CYCLES`, 10: maximum green extension; used only with `TRAFFIC_JAM_EXTEND_EN`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `jam_sensor`  in  NUM_LANES  per-lane congestion flag; level-sensitive; synchronous to `clk`.
- `allow`  out  NUM_LANES  green indication; one-hot or zero.
- `caution`  out  NUM_LANES  yellow indication; one-hot or zero.
- `active_lane`  out  $clog2(NUM_LANES)  index of the lane currently owning green/yellow.

## Operation
- FSM states:
  - `ALL_RED`
  - `GREEN`
  - `YELLOW`
- Transitions:
  - `ALL_RED` → `GREEN` → `YELLOW` → `ALL_RED`.
  - A transition fires on the cycle the phase counter equals 0.
  - On entry to each state, the counter loads that state's duration - 1.
  - The counter decrements by one per cycle and never wraps.
- Output decoding:
  - `allow[active_lane]` is 1 only in `GREEN`.
  - `caution[active_lane]` is 1 only in `YELLOW`.
  - Both vectors are all-zero in `ALL_RED`.
- Outputs are decoded from registered state only; there is no combinational path from `jam_sensor` to any output.
- Lane selection, performed on the `ALL_RED` → `GREEN` edge:
  - Scan lanes cur+1, cur+2, … cur+NUM_LANES (mod NUM_LANES).
  - Pick the first lane with `jam_sensor`=1.
  - If no lane is jammed, pick cur+1 (mod NUM_LANES).
  - The current lane is therefore re-selected only if it is the sole jammed lane.
- `jam_sensor` is sampled only on the selection edge; changes at other times have no effect, except under the extension feature.
- Reset values:
  - State = `ALL_RED`.
  - Counter = `ALL_RED_CYCLES` - 1.
  - `active_lane` = NUM_LANES-1, so the first scan starts at lane 0.
  - `allow` = 0 and `caution` = 0.
- Reset asserted mid-phase: all outputs clear immediately (asynchronous) and the FSM restarts from its reset state; no yellow phase is forced.

## Timing
- After `rst_n` rises:
  - The first green asserts at the `ALL_RED_CYCLES`-th rising edge.
  - With no jam, it goes to lane 0.
- `allow` is high for exactly `GREEN_CYCLES` cycles, plus any extension.
- `caution` is high for exactly `YELLOW_CYCLES` cycles.
- Clearance between any two lanes is exactly `ALL_RED_CYCLES` cycles of all-zero outputs.
- Full rotation period with no jams and no extension: NUM_LANES × (GREEN+YELLOW+ALL_RED) cycles.
- Selection latency: a jam asserted on the selection edge takes effect on that same edge; a jam asserted one cycle later waits for the next cycle of phases.

## Configuration
- `TRAFFIC_JAM_EXTEND_EN` defined:
  - In `GREEN`, when the counter is 0 and `jam_sensor[active_lane]`=1 and the extension count < `MAX_EXTEND_CYCLES`, stay in `GREEN` one more cycle and increment the extension count.
  - The extension count clears on every entry to `GREEN`.
  - Green length ranges from `GREEN_CYCLES` to `GREEN_CYCLES` + `MAX_EXTEND_CYCLES`.
- `TRAFFIC_JAM_EXTEND_EN` undefined:
  - Green is always exactly `GREEN_CYCLES`.
  - The extension counter and `MAX_EXTEND_CYCLES` logic are absent.

## Structure
- `traffic_pkg`:
  - `phase_e` enum (`ALL_RED`, `GREEN`, `YELLOW`).
  - Default duration constants.
- Sub-module `traffic_lane_picker`:
  - Combinational rotating-priority scan.
  - Inputs: `jam_sensor` and current index.
  - Output: next index.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with jams=0 → `allow`=0, `caution`=0, `active_lane`=3; release → `allow`=4'b0001 after edge 2.
- No jams, defaults: `allow` sequence 0001, 0010, 0100, 1000, 0001; each green lasts 10 cycles, yellow 3, all-red 2; period is 60 cycles.
- Jam priority: lane 0 is green and `jam_sensor`=4'b1000 at selection → next green is lane 3, skipping 1 and 2.
- Sole self-jam: lane 2 is active and `jam_sensor`=4'b0100 at selection → lane 2 is re-granted after 2 all-red cycles.
- Extension (macro on): lane 0 is green and `jam_sensor[0]` is held at 1 → green lasts 20 cycles; if jam drops after 14 green cycles → green lasts 14.
- Mid-phase reset: `rst_n`=0 during yellow of lane 1 → `caution` clears asynchronously; after release, the first green goes to lane 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Phase encoding and default timing for the N-lane traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_e;

  localparam int DEF_NUM_LANES      = 4;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_GREEN_CYCLES   = 10;
  localparam int DEF_YELLOW_CYCLES  = 3;
  localparam int DEF_ALL_RED_CYCLES = 2;
  localparam int DEF_MAX_EXTEND     = 10;

endpackage

// File: rtl/traffic_lane_picker.sv
// Rotating-priority scan: first jammed lane after cur, else cur+1.
module traffic_lane_picker
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LW        = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] jam_sensor_i,
  input  logic [LW-1:0]        cur_idx_i,
  output logic [LW-1:0]        next_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    found      = 1'b0;
    idx        = 0;
    next_idx_o = LW'((int'(cur_idx_i) + 1) % NUM_LANES);
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(cur_idx_i) + k) % NUM_LANES;
      if (!found && jam_sensor_i[idx]) begin
        found      = 1'b1;
        next_idx_o = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_controller_n.sv
// N-lane green/yellow/all-red sequencer with jam-priority lane selection.
// Optional green extension on a jammed lane: TRAFFIC_JAM_EXTEND_EN.
module traffic_controller_n
  import traffic_pkg::*;
#(
  parameter int NUM_LANES         = DEF_NUM_LANES,
  parameter int CNT_W             = DEF_CNT_W,
  parameter int GREEN_CYCLES      = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
  parameter int ALL_RED_CYCLES    = DEF_ALL_RED_CYCLES,
  parameter int MAX_EXTEND_CYCLES = DEF_MAX_EXTEND
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_LANES-1:0]         jam_sensor,
  output logic [NUM_LANES-1:0]         allow,
  output logic [NUM_LANES-1:0]         caution,
  output logic [$clog2(NUM_LANES)-1:0] active_lane
);

  localparam int LW = $clog2(NUM_LANES);

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  if (NUM_LANES < 2 || GREEN_CYCLES < 1 ||
      YELLOW_CYCLES < 1 || ALL_RED_CYCLES < 1 ||
      MAX_EXTEND_CYCLES < 0 ||
      (GREEN_CYCLES - 1) >= (1 << CNT_W) ||
      (YELLOW_CYCLES - 1) >= (1 << CNT_W) ||
      (ALL_RED_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("traffic_controller_n: bad parameters");
  end

  phase_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LW-1:0]          lane_q;
  logic [NUM_LANES-1:0]   allow_q;
  logic [NUM_LANES-1:0]   caution_q;
  logic [LW-1:0]          lane_d;

`ifdef TRAFFIC_JAM_EXTEND_EN
  localparam int EXT_W = $clog2(MAX_EXTEND_CYCLES + 2);
  localparam logic [EXT_W-1:0] EXT_MAX =
    EXT_W'(MAX_EXTEND_CYCLES);
  logic [EXT_W-1:0] ext_q;
`endif

  function automatic logic [NUM_LANES-1:0] onehot(
    input logic [LW-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  traffic_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LW        (LW)
  ) u_picker (
    .jam_sensor_i (jam_sensor),
    .cur_idx_i    (lane_q),
    .next_idx_o   (lane_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALL_RED;
      cnt_q     <= R_LOAD;
      lane_q    <= LW'(NUM_LANES - 1);
      allow_q   <= '0;
      caution_q <= '0;
`ifdef TRAFFIC_JAM_EXTEND_EN
      ext_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        ALL_RED: begin
          if (cnt_q == '0) begin
            state_q <= GREEN;
            cnt_q   <= G_LOAD;
            lane_q  <= lane_d;
            allow_q <= onehot(lane_d);
`ifdef TRAFFIC_JAM_EXTEND_EN
            ext_q   <= '0;
`endif
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        GREEN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
`ifdef TRAFFIC_JAM_EXTEND_EN
          // Counter parks at 0 while the extension holds green.
          end else if (jam_sensor[lane_q] &&
                       ext_q < EXT_MAX) begin
            ext_q <= ext_q + EXT_W'(1);
`endif
          end else begin
            state_q   <= YELLOW;
            cnt_q     <= Y_LOAD;
            allow_q   <= '0;
            caution_q <= onehot(lane_q);
          end
        end
        YELLOW: begin
          if (cnt_q == '0) begin
            state_q   <= ALL_RED;
            cnt_q     <= R_LOAD;
            caution_q <= '0;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: begin
          state_q   <= ALL_RED;
          cnt_q     <= R_LOAD;
          allow_q   <= '0;
          caution_q <= '0;
        end
      endcase
    end
  end

  assign allow       = allow_q;
  assign caution     = caution_q;
  assign active_lane = lane_q;

endmodule

// File: tb/tb_traffic_controller_n.sv
// Directed scoreboard bench for traffic_controller_n (4 lanes, defaults).
module tb_traffic_controller_n;

  localparam int N  = 4;
  localparam int G  = 10;
  localparam int Y  = 3;
  localparam int R  = 2;
  localparam int MX = 10;

`ifdef TRAFFIC_JAM_EXTEND_EN
  localparam int EXT_ON = 1;
`else
  localparam int EXT_ON = 0;
`endif

  typedef struct {
    int lane;
    int g;
    int y;
    int r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] jam_sensor;
  logic [N-1:0] allow;
  logic [N-1:0] caution;
  logic [1:0]   active_lane;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   grant_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  traffic_controller_n #(
    .NUM_LANES         (N),
    .CNT_W             (8),
    .GREEN_CYCLES      (G),
    .YELLOW_CYCLES     (Y),
    .ALL_RED_CYCLES    (R),
    .MAX_EXTEND_CYCLES (MX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jam_sensor  (jam_sensor),
    .allow       (allow),
    .caution     (caution),
    .active_lane (active_lane)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input int g);
    exp_t e;
    e.lane = lane;
    e.g    = g;
    e.y    = Y;
    e.r    = R;
    sb.push_back(e);
  endtask

  // Enter at a negedge inside (or before) a green phase.
  // Leaves at the first negedge of the following green.
  task automatic observe(input int drop_after);
    exp_t       e;
    logic [3:0] oh;
    int         n, g, y, r;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e  = sb.pop_front();
    oh = 4'b0001 << e.lane;
    n  = 0;
    while (allow == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    grant_cyc = cyc;
    chk("grant_allow", 32'(allow), 32'(oh));
    chk("grant_lane", 32'(active_lane), e.lane);
    g = 0;
    while (allow != '0 && g < 100) begin
      g++;
      if (g == drop_after) jam_sensor = '0;
      @(negedge clk);
    end
    chk("green_len", g, e.g);
    chk("caution_lane", 32'(caution), 32'(oh));
    y = 0;
    while (caution != '0 && y < 100) begin
      y++;
      @(negedge clk);
    end
    chk("yellow_len", y, e.y);
    r = 0;
    while (allow == '0 && caution == '0 && r < 100) begin
      r++;
      @(negedge clk);
    end
    chk("allred_len", r, e.r);
  endtask

  task automatic first_green(input string tag);
    int n;
    n = 0;
    while (allow == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, R);
  endtask

  initial begin
    int p0;
    int n;
    rst_n      = 1'b0;
    jam_sensor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allow", 32'(allow), 0);
    chk("rst_caution", 32'(caution), 0);
    chk("rst_lane", 32'(active_lane), 3);
    rst_n = 1'b1;
    first_green("first_green_edges");

    for (int l = 0; l < N; l++) push(l, G);
    observe(0);
    p0 = grant_cyc;
    for (int l = 1; l < N; l++) observe(0);
    chk("period", cyc - p0, N * (G + Y + R));

    // Lane 0 green; lane 3 jammed at selection.
    jam_sensor = 4'b1000;
    push(0, G);
    observe(0);
    jam_sensor = '0;
    push(3, G);
    observe(0);
    push(0, G);
    observe(0);
    push(1, G);
    observe(0);

    // Lane 2 green and solely jammed.
    jam_sensor = 4'b0100;
    push(2, G);
    observe(0);
    jam_sensor = '0;
    push(2, G);
    observe(0);
    push(3, G);
    observe(0);

    // Lane 0 green with its own jam held.
    jam_sensor = 4'b0001;
    push(0, EXT_ON ? G + MX : G);
    observe(0);
    push(0, EXT_ON ? 14 : G);
    observe(EXT_ON ? 14 : 8);
    chk("jam_dropped", 32'(jam_sensor), 0);

    // Lane 1 green now; reset during its yellow.
    n = 0;
    while (caution == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_yellow", 32'(caution), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_caution", 32'(caution), 0);
    chk("mid_rst_allow", 32'(allow), 0);
    chk("mid_rst_lane", 32'(active_lane), 3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_green("restart_edges");
    push(0, G);
    observe(0);
    chk("after_restart", 32'(active_lane), 1);
    chk("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
